// File: rtl/riscv_partial_store_if.sv
// Store-alignment bus: instruction/operands in, lane-aligned store payload out.
interface riscv_partial_store_if;
    logic [31:0] instruction;
    logic [31:0] data_from_reg;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] data_to_mem;
    logic [3:0]  mem_write_mask;
    logic        store_misaligned;

    // Upstream pipeline stage drives the request and observes the result.
    modport master (
        output instruction, data_from_reg, mem_addr, mem_wen,
        input  data_to_mem, mem_write_mask, store_misaligned
    );

    // The alignment stage consumes the request and drives the result.
    modport slave (
        input  instruction, data_from_reg, mem_addr, mem_wen,
        output data_to_mem, mem_write_mask, store_misaligned
    );
endinterface

// File: rtl/riscv_partial_store.sv
// RV32I store-alignment stage: places SB/SH/SW data on byte lanes and builds the
// byte write mask, one registered cycle ahead of the data memory.
module riscv_partial_store (
    input  logic                  clk,
    input  logic                  rst,
    riscv_partial_store_if.slave  bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned MASK_W = 4;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;
    localparam logic [2:0]  F3_SB = 3'b000;
    localparam logic [2:0]  F3_SH = 3'b001;
    localparam logic [2:0]  F3_SW = 3'b010;

    logic              is_store_c;
    logic [2:0]        f3_c;
    logic [1:0]        off_c;
    logic              mis_c;
    logic [XLEN-1:0]   data_c;
    logic [MASK_W-1:0] mask_c;

    // Instruction and upper address bits outside the decoded fields are don't-care.
    logic unused_bits;
    assign unused_bits = ^{bus.instruction[31:15], bus.instruction[11:7], bus.mem_addr[31:2]};

    assign is_store_c = (bus.instruction[6:0] == OPC_STORE);
    assign f3_c       = bus.instruction[14:12];
    assign off_c      = bus.mem_addr[1:0];

    // Lane placement, misalignment detection and write-mask generation.
    always_comb begin
        data_c = bus.data_from_reg;
        mis_c  = 1'b0;
        mask_c = '0;

        // Data shaping is independent of mem_wen so the lanes are always well defined.
        if (is_store_c) begin
            unique case (f3_c)
                F3_SB:   data_c = XLEN'({24'h0, bus.data_from_reg[7:0]}) << {off_c, 3'b000};
                F3_SH:   data_c = XLEN'({16'h0, bus.data_from_reg[15:0]}) << {off_c[1], 4'b0000};
                default: data_c = bus.data_from_reg;
            endcase
        end

        if (is_store_c) begin
            unique case (f3_c)
                F3_SH:   mis_c = off_c[0];
                F3_SW:   mis_c = (off_c != 2'b00);
                default: mis_c = 1'b0;
            endcase
        end

        // A misaligned access must not touch memory, so it gets an empty mask.
        if (bus.mem_wen && is_store_c && !mis_c) begin
            unique case (f3_c)
                F3_SB:   mask_c = MASK_W'(4'b0001) << off_c;
                F3_SH:   mask_c = MASK_W'(4'b0011) << {off_c[1], 1'b0};
                F3_SW:   mask_c = MASK_W'(4'b1111);
                default: mask_c = '0;
            endcase
        end
    end

    // Output register; synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_to_mem      <= '0;
            bus.mem_write_mask   <= '0;
            bus.store_misaligned <= 1'b0;
        end else begin
            bus.data_to_mem      <= data_c;
            bus.mem_write_mask   <= mask_c;
            bus.store_misaligned <= mis_c & bus.mem_wen & is_store_c;
        end
    end
endmodule

// File: tb/tb_riscv_partial_store.sv
// Directed bench for the store-alignment stage.
module tb_riscv_partial_store;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    riscv_partial_store_if bus ();

    riscv_partial_store dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
        logic        exp_mis;
    } vec_t;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    // Fills unused instruction fields with junk so they are shown not to matter.
    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
        return {17'h15A5A, f3, 5'h1B, opc};
    endfunction

    function automatic vec_t v(input logic [31:0] instr, input logic [31:0] data,
                               input logic [31:0] addr, input logic wen,
                               input logic [31:0] ed, input logic [3:0] em, input logic mis);
        vec_t r;
        r.instr = instr; r.data = data; r.addr = addr; r.wen = wen;
        r.exp_data = ed; r.exp_mask = em; r.exp_mis = mis;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        bus.instruction   = x.instr;
        bus.data_from_reg = x.data;
        bus.mem_addr      = x.addr;
        bus.mem_wen       = x.wen;
    endtask

    task automatic test_reset();
        vec_t x;
        x = v(mk(3'b010, OPC_STORE), 32'h89ABCDEF, 32'h0, 1'b1, 32'h89ABCDEF, 4'b1111, 1'b0);
        rst = 1'b1;
        drive(x);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== 32'h0 || bus.mem_write_mask !== 4'b0000 || bus.store_misaligned !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got data=%h mask=%b mis=%b, want 00000000/0000/0",
                         c, bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.data_to_mem !== x.exp_data || bus.mem_write_mask !== x.exp_mask || bus.store_misaligned !== x.exp_mis) begin
            n_fail++;
            $display("FAIL reset_release: got data=%h mask=%b mis=%b, want %h/%b/%b",
                     bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                     x.exp_data, x.exp_mask, x.exp_mis);
        end
    endtask

    task automatic test_sb();
        vec_t t[4];
        t[0] = v(mk(3'b000, OPC_STORE), 32'h12345678, 32'h0, 1'b1, 32'h00000078, 4'b0001, 1'b0);
        t[1] = v(mk(3'b000, OPC_STORE), 32'h12345678, 32'h1, 1'b1, 32'h00007800, 4'b0010, 1'b0);
        t[2] = v(mk(3'b000, OPC_STORE), 32'h12345678, 32'h2, 1'b1, 32'h00780000, 4'b0100, 1'b0);
        t[3] = v(mk(3'b000, OPC_STORE), 32'h12345678, 32'hFFFF_FFF3, 1'b1, 32'h78000000, 4'b1000, 1'b0);
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== t[i].exp_data || bus.mem_write_mask !== t[i].exp_mask || bus.store_misaligned !== t[i].exp_mis) begin
                n_fail++;
                $display("FAIL sb[%0d]: got data=%h mask=%b mis=%b, want %h/%b/%b", i,
                         bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                         t[i].exp_data, t[i].exp_mask, t[i].exp_mis);
            end
        end
    endtask

    task automatic test_sh();
        vec_t t[4];
        t[0] = v(mk(3'b001, OPC_STORE), 32'h12345678, 32'h0, 1'b1, 32'h00005678, 4'b0011, 1'b0);
        t[1] = v(mk(3'b001, OPC_STORE), 32'h12345678, 32'h2, 1'b1, 32'h56780000, 4'b1100, 1'b0);
        t[2] = v(mk(3'b001, OPC_STORE), 32'h12345678, 32'h1, 1'b1, 32'h00005678, 4'b0000, 1'b1);
        t[3] = v(mk(3'b001, OPC_STORE), 32'h12345678, 32'h3, 1'b1, 32'h56780000, 4'b0000, 1'b1);
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== t[i].exp_data || bus.mem_write_mask !== t[i].exp_mask || bus.store_misaligned !== t[i].exp_mis) begin
                n_fail++;
                $display("FAIL sh[%0d]: got data=%h mask=%b mis=%b, want %h/%b/%b", i,
                         bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                         t[i].exp_data, t[i].exp_mask, t[i].exp_mis);
            end
        end
    endtask

    task automatic test_sw();
        vec_t t[3];
        t[0] = v(mk(3'b010, OPC_STORE), 32'h89ABCDEF, 32'h4, 1'b1, 32'h89ABCDEF, 4'b1111, 1'b0);
        t[1] = v(mk(3'b010, OPC_STORE), 32'h89ABCDEF, 32'h6, 1'b1, 32'h89ABCDEF, 4'b0000, 1'b1);
        t[2] = v(mk(3'b010, OPC_STORE), 32'h89ABCDEF, 32'h5, 1'b1, 32'h89ABCDEF, 4'b0000, 1'b1);
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== t[i].exp_data || bus.mem_write_mask !== t[i].exp_mask || bus.store_misaligned !== t[i].exp_mis) begin
                n_fail++;
                $display("FAIL sw[%0d]: got data=%h mask=%b mis=%b, want %h/%b/%b", i,
                         bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                         t[i].exp_data, t[i].exp_mask, t[i].exp_mis);
            end
        end
    endtask

    task automatic test_write_disabled();
        vec_t t[3];
        t[0] = v(mk(3'b010, OPC_STORE), 32'hAAAAAAAA, 32'h0, 1'b0, 32'hAAAAAAAA, 4'b0000, 1'b0);
        t[1] = v(mk(3'b010, OPC_STORE), 32'hAAAAAAAA, 32'h2, 1'b0, 32'hAAAAAAAA, 4'b0000, 1'b0);
        t[2] = v(mk(3'b000, OPC_STORE), 32'h000000C3, 32'h1, 1'b0, 32'h0000C300, 4'b0000, 1'b0);
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== t[i].exp_data || bus.mem_write_mask !== t[i].exp_mask || bus.store_misaligned !== t[i].exp_mis) begin
                n_fail++;
                $display("FAIL wen0[%0d]: got data=%h mask=%b mis=%b, want %h/%b/%b", i,
                         bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                         t[i].exp_data, t[i].exp_mask, t[i].exp_mis);
            end
        end
    endtask

    task automatic test_non_store();
        vec_t t[4];
        t[0] = v(mk(3'b000, OPC_RTYPE), 32'h12345678, 32'h0, 1'b1, 32'h12345678, 4'b0000, 1'b0);
        t[1] = v(mk(3'b000, OPC_RTYPE), 32'h12345678, 32'h1, 1'b1, 32'h12345678, 4'b0000, 1'b0);
        t[2] = v(mk(3'b010, OPC_RTYPE), 32'h12345678, 32'h2, 1'b1, 32'h12345678, 4'b0000, 1'b0);
        t[3] = v(mk(3'b011, OPC_STORE), 32'h12345678, 32'h3, 1'b1, 32'h12345678, 4'b0000, 1'b0);
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== t[i].exp_data || bus.mem_write_mask !== t[i].exp_mask || bus.store_misaligned !== t[i].exp_mis) begin
                n_fail++;
                $display("FAIL nonstore[%0d]: got data=%h mask=%b mis=%b, want %h/%b/%b", i,
                         bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                         t[i].exp_data, t[i].exp_mask, t[i].exp_mis);
            end
        end
    endtask

    // New vector every cycle; before each edge the previous result must still be held.
    task automatic test_back_to_back();
        vec_t t[6];
        t[0] = v(mk(3'b000, OPC_STORE), 32'hDEADBEEF, 32'h3, 1'b1, 32'hEF000000, 4'b1000, 1'b0);
        t[1] = v(mk(3'b001, OPC_STORE), 32'hDEADBEEF, 32'h2, 1'b1, 32'hBEEF0000, 4'b1100, 1'b0);
        t[2] = v(mk(3'b010, OPC_STORE), 32'hCAFEF00D, 32'h8, 1'b1, 32'hCAFEF00D, 4'b1111, 1'b0);
        t[3] = v(mk(3'b000, OPC_STORE), 32'h000000A5, 32'h1, 1'b1, 32'h0000A500, 4'b0010, 1'b0);
        t[4] = v(mk(3'b001, OPC_STORE), 32'h0000BEEF, 32'h0, 1'b1, 32'h0000BEEF, 4'b0011, 1'b0);
        t[5] = v(mk(3'b010, OPC_STORE), 32'h01020304, 32'h3, 1'b1, 32'h01020304, 4'b0000, 1'b1);
        foreach (t[i]) begin
            drive(t[i]);
            if (i > 0) begin
                #2;
                n_checks++;
                if (bus.data_to_mem !== t[i-1].exp_data || bus.mem_write_mask !== t[i-1].exp_mask) begin
                    n_fail++;
                    $display("FAIL b2b_hold[%0d]: got data=%h mask=%b, want %h/%b", i,
                             bus.data_to_mem, bus.mem_write_mask, t[i-1].exp_data, t[i-1].exp_mask);
                end
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.data_to_mem !== t[i].exp_data || bus.mem_write_mask !== t[i].exp_mask || bus.store_misaligned !== t[i].exp_mis) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got data=%h mask=%b mis=%b, want %h/%b/%b", i,
                         bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned,
                         t[i].exp_data, t[i].exp_mask, t[i].exp_mis);
            end
        end
    endtask

    // Reset asserted mid-stream must clear outputs despite a valid store on the inputs.
    task automatic test_reset_midstream();
        rst = 1'b1;
        drive(v(mk(3'b010, OPC_STORE), 32'h55AA55AA, 32'h0, 1'b1, 32'h0, 4'b0, 1'b0));
        @(posedge clk); #1;
        n_checks++;
        if (bus.data_to_mem !== 32'h0 || bus.mem_write_mask !== 4'b0000 || bus.store_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: got data=%h mask=%b mis=%b, want 00000000/0000/0",
                     bus.data_to_mem, bus.mem_write_mask, bus.store_misaligned);
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.instruction   = '0;
        bus.data_from_reg = '0;
        bus.mem_addr      = '0;
        bus.mem_wen       = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_write_disabled();
        test_non_store();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_partial_store.md
Name: riscv_partial_store

Overview:
Store-alignment stage of the RV32I datapath, sitting between the register-read/ALU stage and the byte-maskable data memory. It decodes a store instruction (SB/SH/SW) and the low address bits, then places the register data on the correct byte lanes with zeros elsewhere. It also produces the 4-bit byte write mask and flags misaligned stores. Outputs are registered: one cycle of latency, synchronous active-high reset.

Parameters:
None. Data path is fixed at 32 bits, mask at 4 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
instruction  input  32  full RV32 instruction word; uses [6:0] opcode and [14:12] funct3
data_from_reg  input  32  rs2 value to be stored
mem_addr  input  32  effective byte address; only [1:0] used
mem_wen  input  1  store permitted this cycle
data_to_mem  output  32  lane-aligned store data (registered)
mem_write_mask  output  4  byte write enables, bit i = byte lane i (bits [8i+7:8i]) (registered)
store_misaligned  output  1  misaligned store flag (registered)

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- On rst=1 at a rising edge: data_to_mem=32'h0, mem_write_mask=4'b0000, store_misaligned=0. Reset wins over all inputs. Reset held for several cycles keeps outputs at zero.
- Otherwise, every rising edge registers the combinational results below. Inputs sampled at edge N appear on outputs after edge N; no handshake.
- is_store = (instruction[6:0] == OPC_STORE, 7'b0100011). f3 = instruction[14:12]. off = mem_addr[1:0].
- Data formatting applies regardless of mem_wen:
  - SB (f3=000): data = data_from_reg[7:0] << (8*off); all other bits 0.
  - SH (f3=001): data = data_from_reg[15:0] << (16*off[1]); all other bits 0. off[0] is ignored.
  - SW (f3=010): data = data_from_reg unchanged.
  - Non-store opcode or other f3: data = data_from_reg unchanged.
- Misalignment (combinational term mis):
  - Set for SH with off[0]=1.
  - Set for SW with off!=00.
  - Never set for SB.
  - Only set when is_store=1.
- Mask is 4'b0000 if mem_wen=0, is_store=0, f3 is not 000/001/010, or mis=1. Otherwise:
  - SB: 4'b0001 << off.
  - SH: 4'b0011 << (2*off[1]).
  - SW: 4'b1111.
- store_misaligned = mis & mem_wen & is_store. It is a pure flag; no trap logic in this block.
- mem_addr[31:2] and all other instruction bits do not affect outputs.
- Downstream memory must write only lanes whose mask bit is 1. Unmasked lanes of data_to_mem are don't-care to memory, but must be the zero values specified above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with SW, wen=1, data 0x89ABCDEF -> outputs 0x00000000 / 4'b0000 / 0. Release rst -> next edge gives 0x89ABCDEF / 4'b1111.
- SB, addr 0x0 -> 0x00000078 / 0001. SB, addr 0x2 -> 0x00780000 / 0100. SB, addr 0x3 -> 0x78000000 / 1000. Data 0x12345678, wen=1 throughout; each result one cycle after the input.
- SH, data 0x12345678, addr 0x0 -> 0x00005678 / 0011. Addr 0x2 -> 0x56780000 / 1100. Addr 0x1 -> mask 0000, store_misaligned=1.
- SW, data 0x89ABCDEF, addr 0x4 -> 0x89ABCDEF / 1111. Addr 0x6 -> mask 0000, store_misaligned=1.
- Write disabled: SW, wen=0, data 0xAAAAAAAA, addr 0x0 -> data_to_mem 0xAAAAAAAA, mask 0000, misaligned 0.
- Non-store: opcode 0110011 (R-type), wen=1, data 0x12345678 -> data 0x12345678, mask 0000. Back-to-back SB/SH/SW every cycle -> outputs track with exactly 1-cycle latency.
